// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-read / single-write register file with a
// per-register pending-write counter that stalls ID on RAW hazards.
// Optional feature macro: REGFILE_BYPASS_EN (WB-to-read forwarding that
// also releases the hazard in the retiring cycle).
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter int NUM_RD   = 2,
    parameter int PEND_W   = 2,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD-1:0]        rd_use,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     iss_valid,
    input  logic                     iss_wr,
    input  logic [ADDR_W-1:0]        iss_rd,
    output logic                     stall,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     clr_pend,
    output logic                     err
);
    localparam int                NREGS    = 2**ADDR_W;
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [PEND_W-1:0] r_pend [NREGS];
    logic              r_err;

    logic              w_iss_zero;
    logic              w_wb_zero;
    logic              w_ret;
    logic              w_sat;
    logic              w_acc;
    logic [NUM_RD-1:0] w_haz;

    // r0 is hardwired only when ZERO_REG is set; it never issues or retires
    assign w_iss_zero = ZERO_REG && (iss_rd == '0);
    assign w_wb_zero  = ZERO_REG && (wb_addr == '0);
    assign w_ret      = wb_en && !w_wb_zero;

    // A full counter can still take an issue if the same register retires now
    assign w_sat = iss_valid && iss_wr && (r_pend[iss_rd] == PEND_MAX) &&
                   !(wb_en && (wb_addr == iss_rd));

    assign stall = iss_valid && ((|w_haz) || w_sat);
    assign w_acc = iss_valid && iss_wr && !stall && !w_iss_zero;
    assign err   = r_err;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_a;
        logic              w_pend_nz;
        assign w_a       = rd_addr[i*ADDR_W +: ADDR_W];
        assign w_pend_nz = (r_pend[w_a] != '0);
`ifdef REGFILE_BYPASS_EN
        logic w_wb_hit;
        assign w_wb_hit = w_ret && (wb_addr == w_a);
        // Last outstanding write retiring now: forward it and drop the hazard
        assign w_haz[i] = rd_use[i] && w_pend_nz &&
                          !(w_wb_hit && (r_pend[w_a] == PEND_ONE));
        assign rd_data[i*DATA_W +: DATA_W] =
            (ZERO_REG && (w_a == '0)) ? '0 :
            w_wb_hit                  ? wb_data : r_regs[w_a];
`else
        assign w_haz[i] = rd_use[i] && w_pend_nz;
        assign rd_data[i*DATA_W +: DATA_W] =
            (ZERO_REG && (w_a == '0)) ? '0 : r_regs[w_a];
`endif
    end

    // Register storage: WB writes whenever it retires, flush or not
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) r_regs[r] <= '0;
        end else if (w_ret) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // Pending counters: issue increments, retire decrements, flush zeroes all
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) r_pend[r] <= '0;
        end else if (clr_pend) begin
            for (int r = 0; r < NREGS; r++) r_pend[r] <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (w_acc && (iss_rd == ADDR_W'(r)) &&
                    !(w_ret && (wb_addr == ADDR_W'(r)) && (r_pend[r] != '0)))
                    r_pend[r] <= r_pend[r] + PEND_ONE;
                else if (!(w_acc && (iss_rd == ADDR_W'(r))) &&
                         w_ret && (wb_addr == ADDR_W'(r)) && (r_pend[r] != '0))
                    r_pend[r] <= r_pend[r] - PEND_ONE;
            end
        end
    end

    // Sticky flag for a write-back nobody issued (counter already zero)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err <= 1'b0;
        else if (w_ret && (r_pend[wb_addr] == '0) && !clr_pend)
            r_err <= 1'b1;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one default instance and one with
// ZERO_REG=1 driven by the same stimulus. Expectations follow REGFILE_BYPASS_EN.
module tb_regfile_scoreboard;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NR = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR*AW-1:0] rd_addr;
    logic [NR-1:0]    rd_use;
    logic             iss_valid, iss_wr;
    logic [AW-1:0]    iss_rd;
    logic             wb_en;
    logic [AW-1:0]    wb_addr;
    logic [DW-1:0]    wb_data;
    logic             clr_pend;

    logic [NR*DW-1:0] rd_data0, rd_data1;
    logic             stall0, stall1, err0, err1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .PEND_W(2), .ZERO_REG(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_use(rd_use), .rd_data(rd_data0),
        .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_rd(iss_rd), .stall(stall0),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .clr_pend(clr_pend), .err(err0));

    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .PEND_W(2), .ZERO_REG(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_use(rd_use), .rd_data(rd_data1),
        .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_rd(iss_rd), .stall(stall1),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .clr_pend(clr_pend), .err(err1));

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rd_addr = '0; rd_use = '0;
        iss_valid = 1'b0; iss_wr = 1'b0; iss_rd = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; clr_pend = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_wr(input logic [AW-1:0] r);
        idle();
        iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = r;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset: write r5 (unissued -> err), make r5 pending, then async reset
        idle(); wb_en = 1'b1; wb_addr = 6'd5; wb_data = 32'h1234; tick();
        idle(); rd_addr = {6'd0, 6'd5}; #1;
        chk("pre_rst_r5", rd_data0[31:0], 32'h1234);
        chk("pre_rst_err", {31'd0, err0}, 32'd1);
        issue_wr(6'd5); tick();
        idle(); iss_valid = 1'b1; rd_addr = {6'd0, 6'd5}; rd_use = 2'b01; #1;
        chk("pre_rst_stall", {31'd0, stall0}, 32'd1);
        rst_n = 1'b0; #1;
        chk("rst_rd0", rd_data0[31:0], 32'h0);
        chk("rst_stall", {31'd0, stall0}, 32'd0);
        chk("rst_err", {31'd0, err0}, 32'd0);
        rst_n = 1'b1; idle(); tick();
        idle(); iss_valid = 1'b1; rd_addr = {6'd0, 6'd5}; rd_use = 2'b01; #1;
        chk("post_rst_r5", rd_data0[31:0], 32'h0);
        chk("post_rst_stall", {31'd0, stall0}, 32'd0);
        tick();

        // Basic RAW on r3
        issue_wr(6'd3); #1;
        chk("raw_issue_stall", {31'd0, stall0}, 32'd0);
        tick();
        idle(); iss_valid = 1'b1; rd_addr = {6'd0, 6'd3}; rd_use = 2'b01; #1;
        chk("raw_c2_stall", {31'd0, stall0}, 32'd1);
        tick();
        wb_en = 1'b1; wb_addr = 6'd3; wb_data = 32'hDEADBEEF; #1;
`ifdef REGFILE_BYPASS_EN
        chk("raw_c3_stall", {31'd0, stall0}, 32'd0);
        chk("raw_c3_data", rd_data0[31:0], 32'hDEADBEEF);
`else
        chk("raw_c3_stall", {31'd0, stall0}, 32'd1);
`endif
        tick();
        wb_en = 1'b0; #1;
        chk("raw_c4_stall", {31'd0, stall0}, 32'd0);
        chk("raw_c4_data", rd_data0[31:0], 32'hDEADBEEF);
        chk("raw_err", {31'd0, err0}, 32'd0);
        tick();

        // Saturation on r7
        for (int k = 0; k < 3; k++) begin
            issue_wr(6'd7); #1;
            chk("sat_fill_stall", {31'd0, stall0}, 32'd0);
            tick();
        end
        issue_wr(6'd7); #1;
        chk("sat_full_stall", {31'd0, stall0}, 32'd1);
        wb_en = 1'b1; wb_addr = 6'd7; wb_data = 32'h77; #1;
        chk("sat_wb_stall", {31'd0, stall0}, 32'd0);
        tick();
        issue_wr(6'd7); #1;
        chk("sat_still_full", {31'd0, stall0}, 32'd1);
        idle(); clr_pend = 1'b1; tick();
        idle(); iss_valid = 1'b1; rd_addr = {6'd0, 6'd7}; rd_use = 2'b01; #1;
        chk("sat_clr_stall", {31'd0, stall0}, 32'd0);
        chk("sat_r7_data", rd_data0[31:0], 32'h77);
        chk("sat_err", {31'd0, err0}, 32'd0);
        tick();

        // rd_use gating with r9 pending on port 1
        issue_wr(6'd9); tick();
        idle(); iss_valid = 1'b1; rd_addr = {6'd9, 6'd3}; rd_use = 2'b01; #1;
        chk("use_gated_stall", {31'd0, stall0}, 32'd0);
        chk("use_port0_data", rd_data0[31:0], 32'hDEADBEEF);
        rd_use = 2'b10; #1;
        chk("use_active_stall", {31'd0, stall0}, 32'd1);
        idle(); clr_pend = 1'b1; tick();

        // Flush with simultaneous WB, then underflow WB
        issue_wr(6'd4); tick();
        issue_wr(6'd4); tick();
        idle(); clr_pend = 1'b1; wb_en = 1'b1; wb_addr = 6'd4; wb_data = 32'h11; tick();
        idle(); iss_valid = 1'b1; rd_addr = {6'd4, 6'd0}; rd_use = 2'b10; #1;
        chk("flush_err", {31'd0, err0}, 32'd0);
        chk("flush_stall", {31'd0, stall0}, 32'd0);
        chk("flush_r4", rd_data0[63:32], 32'h11);
        idle(); wb_en = 1'b1; wb_addr = 6'd4; wb_data = 32'h22; tick();
        idle(); rd_addr = {6'd4, 6'd0}; #1;
        chk("under_err", {31'd0, err0}, 32'd1);
        chk("under_r4", rd_data0[63:32], 32'h22);
        tick();
        chk("under_err_sticky", {31'd0, err0}, 32'd1);

        // ZERO_REG: clean state, then issue/read/write r0 on both instances
        rst_n = 1'b0; #1; rst_n = 1'b1; idle(); tick();
        issue_wr(6'd0); tick();
        idle(); iss_valid = 1'b1; rd_addr = {6'd0, 6'd0}; rd_use = 2'b01; #1;
        chk("z1_r0_stall", {31'd0, stall1}, 32'd0);
        chk("z1_r0_data", rd_data1[31:0], 32'h0);
        chk("z0_r0_stall", {31'd0, stall0}, 32'd1);
        idle(); wb_en = 1'b1; wb_addr = 6'd0; wb_data = 32'h5; tick();
        idle(); iss_valid = 1'b1; rd_addr = {6'd0, 6'd0}; rd_use = 2'b01; #1;
        chk("z1_r0_after_wb", rd_data1[31:0], 32'h0);
        chk("z1_err", {31'd0, err1}, 32'd0);
        chk("z0_r0_after_wb", rd_data0[31:0], 32'h5);
        chk("z0_err", {31'd0, err0}, 32'd0);
        chk("z0_r0_released", {31'd0, stall0}, 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
